// File: rtl/comb_chk_pkg.sv
// Shared types and defaults for the combinational-model result checker.
// Sweep length is always the full input space of the compared models.
package comb_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } chk_state_t;

    localparam int unsigned DEF_VEC_W      = 4;
    localparam int unsigned DEF_NUM_MODELS = 4;
    localparam int unsigned DEF_CNT_W      = 8;

    localparam int unsigned SWEEP_LEN = 1 << DEF_VEC_W;

    function automatic int unsigned sweep_len(input int unsigned vec_w);
        return 1 << vec_w;
    endfunction

endpackage

// File: rtl/comb_vec_checker_if.sv
// Sample and result bundle between the stimulus source (master) and the checker (slave).
interface comb_vec_checker_if
    import comb_chk_pkg::*;
#(
    parameter int unsigned VEC_W      = DEF_VEC_W,
    parameter int unsigned NUM_MODELS = DEF_NUM_MODELS,
    parameter int unsigned CNT_W      = DEF_CNT_W
);
    logic                  start;
    logic                  in_valid;
    logic [VEC_W-1:0]      in_vec;
    logic [NUM_MODELS-1:0] model_out;

    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [CNT_W-1:0]      err_cnt;
    logic [VEC_W:0]        vec_cnt;
    logic                  fail_seen;
    logic [VEC_W-1:0]      first_fail_vec;
    logic [NUM_MODELS-1:0] first_fail_mask;

    modport master (
        output start, in_valid, in_vec, model_out,
        input  busy, done, pass, err_cnt, vec_cnt, fail_seen, first_fail_vec, first_fail_mask
    );

    modport slave (
        input  start, in_valid, in_vec, model_out,
        output busy, done, pass, err_cnt, vec_cnt, fail_seen, first_fail_vec, first_fail_mask
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous reset and clear.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);
    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/comb_vec_checker.sv
// Compares NUM_MODELS model outputs against model 0 over a full input sweep and
// registers a verdict. Define COMB_CHK_COVERAGE_EN to require every vector be seen.
module comb_vec_checker
    import comb_chk_pkg::*;
#(
    parameter int unsigned VEC_W      = DEF_VEC_W,
    parameter int unsigned NUM_MODELS = DEF_NUM_MODELS,
    parameter int unsigned CNT_W      = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    comb_vec_checker_if.slave bus
);
    localparam int unsigned    SweepLen = sweep_len(VEC_W);
    localparam logic [VEC_W:0] LastCnt  = (VEC_W + 1)'(SweepLen - 1);
    localparam logic [VEC_W:0] VecOne   = (VEC_W + 1)'(1);

    chk_state_t state_q, state_d;

    logic                  accept;
    logic                  mismatch;
    logic                  sweep_end;
    logic                  cov_ok;
    logic                  err_zero;
    logic [NUM_MODELS-1:0] diff_mask;

    logic                  busy_q, done_q, pass_q, fail_seen_q;
    logic [VEC_W:0]        vec_cnt_q;
    logic [VEC_W-1:0]      first_fail_vec_q;
    logic [NUM_MODELS-1:0] first_fail_mask_q;
    logic [CNT_W-1:0]      err_cnt;

    assign diff_mask = bus.model_out ^ {NUM_MODELS{bus.model_out[0]}};
    assign mismatch  = |diff_mask;
    // start has priority: a sample arriving with start is dropped
    assign accept    = (state_q == RUN) && bus.in_valid && !bus.start;
    assign sweep_end = accept && (vec_cnt_q == LastCnt);
    // Verdict looks at the counter including the sample completing the sweep
    assign err_zero  = (err_cnt == '0) && !mismatch;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.start) begin
                    state_d = RUN;
                end else if (sweep_end) begin
                    state_d = DONE;
                end
            end
            DONE: if (bus.start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == RUN);
            done_q  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            pass_q <= 1'b0;
        end else if (sweep_end) begin
            pass_q <= err_zero && cov_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            vec_cnt_q <= '0;
        end else if (accept) begin
            vec_cnt_q <= vec_cnt_q + VecOne;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            fail_seen_q       <= 1'b0;
            first_fail_vec_q  <= '0;
            first_fail_mask_q <= '0;
        end else if (accept && mismatch && !fail_seen_q) begin
            fail_seen_q       <= 1'b1;
            first_fail_vec_q  <= bus.in_vec;
            first_fail_mask_q <= diff_mask;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.start),
        .en  (accept && mismatch),
        .cnt (err_cnt)
    );

`ifdef COMB_CHK_COVERAGE_EN
    logic [SweepLen-1:0] cov_q;
    logic [SweepLen-1:0] cov_hit;
    logic [SweepLen-1:0] cov_set;

    always_comb begin
        cov_hit             = '0;
        cov_hit[bus.in_vec] = 1'b1;
    end

    assign cov_set = cov_q | cov_hit;
    assign cov_ok  = &cov_set;

    always_ff @(posedge clk) begin
        if (rst || bus.start) begin
            cov_q <= '0;
        end else if (accept) begin
            cov_q <= cov_set;
        end
    end
`else
    assign cov_ok = 1'b1;
`endif

    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.pass            = pass_q;
    assign bus.err_cnt         = err_cnt;
    assign bus.vec_cnt         = vec_cnt_q;
    assign bus.fail_seen       = fail_seen_q;
    assign bus.first_fail_vec  = first_fail_vec_q;
    assign bus.first_fail_mask = first_fail_mask_q;

endmodule

// File: tb/tb_comb_vec_checker.sv
// Directed and randomized bench for comb_vec_checker with a sweep-level reference model.
// Honors COMB_CHK_COVERAGE_EN when predicting the duplicate-vector verdict.
module tb_comb_vec_checker;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    comb_vec_checker_if #(.VEC_W(4), .NUM_MODELS(4), .CNT_W(8)) if0 ();
    comb_vec_checker_if #(.VEC_W(4), .NUM_MODELS(4), .CNT_W(2)) if2 ();

    comb_vec_checker #(.VEC_W(4), .NUM_MODELS(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    comb_vec_checker #(.VEC_W(4), .NUM_MODELS(4), .CNT_W(2)) dut_sat (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    always #5 clk = ~clk;

    // Reference model state, tracking the whole sweep at transaction level
    bit       m_busy, m_done, m_pass, m_fail;
    int       m_cnt, m_err;
    bit [3:0] m_fvec, m_fmask;
    bit       m_cov [16];

    function automatic logic gold(input logic [3:0] v);
        return (v[3] & v[2]) | (~v[1] & v[0]);
    endfunction

    function automatic logic [3:0] agree(input logic [3:0] v);
        return {4{gold(v)}};
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_err = 0; m_fail = 0; m_fvec = 0; m_fmask = 0; m_pass = 0;
        foreach (m_cov[i]) m_cov[i] = 0;
    endtask

    task automatic model_step(input bit s, input bit v, input bit [3:0] vec, input bit [3:0] mo);
        bit all_cov;
        if (s) begin
            model_clear();
            m_busy = 1; m_done = 0;
        end else if (m_busy && v) begin
            m_cnt++;
            m_cov[vec] = 1;
            if (!(mo == 4'h0 || mo == 4'hF)) begin
                if (m_err < 255) m_err++;
                if (!m_fail) begin
                    m_fail  = 1;
                    m_fvec  = vec;
                    m_fmask = mo[0] ? ~mo : mo;
                end
            end
            if (m_cnt == 16) begin
                all_cov = 1;
`ifdef COMB_CHK_COVERAGE_EN
                foreach (m_cov[i]) if (!m_cov[i]) all_cov = 0;
`endif
                m_busy = 0; m_done = 1;
                m_pass = (m_err == 0) && all_cov;
            end
        end
    endtask

    task automatic cyc(input bit s, input bit v, input bit [3:0] vec, input bit [3:0] mo);
        @(negedge clk);
        if0.start = s; if0.in_valid = v; if0.in_vec = vec; if0.model_out = mo;
        model_step(s, v, vec, mo);
    endtask

    task automatic idle();
        cyc(0, 0, 4'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        if0.start = 0; if0.in_valid = 0;
        model_clear();
        m_busy = 0; m_done = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({if0.busy, if0.done, if0.pass, if0.fail_seen} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {if0.busy, if0.done, if0.pass, if0.fail_seen});
        end
        checks++;
        if ({if0.err_cnt, if0.vec_cnt, if0.first_fail_vec, if0.first_fail_mask} !== 21'd0) begin
            failures++;
            $display("FAIL reset_stats: got %h expected 0",
                     {if0.err_cnt, if0.vec_cnt, if0.first_fail_vec, if0.first_fail_mask});
        end
        do_reset();
    endtask

    task automatic test_clean_sweep();
        cyc(1, 0, 0, 0);
        idle();
        checks++;
        if (if0.busy !== 1'b1) begin
            failures++; $display("FAIL busy_after_start: got %b expected 1", if0.busy);
        end
        for (int i = 0; i < 16; i++) cyc(0, 1, 4'(i), agree(4'(i)));
        idle();
        checks++;
        if ({if0.done, if0.pass, if0.busy, if0.fail_seen} !== 4'b1100) begin
            failures++;
            $display("FAIL clean_verdict: got done/pass/busy/fail=%b expected 1100",
                     {if0.done, if0.pass, if0.busy, if0.fail_seen});
        end
        checks++;
        if (if0.err_cnt !== 8'd0 || if0.vec_cnt !== 5'd16) begin
            failures++;
            $display("FAIL clean_counts: got err=%0d vec=%0d expected err=0 vec=16",
                     if0.err_cnt, if0.vec_cnt);
        end
    endtask

    task automatic test_fault();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5 || i == 9) cyc(0, 1, 4'(i), agree(4'(i)) ^ 4'b0100);
            else cyc(0, 1, 4'(i), agree(4'(i)));
        end
        idle();
        checks++;
        if (if0.err_cnt !== 8'd2) begin
            failures++; $display("FAIL fault_err_cnt: got %0d expected 2", if0.err_cnt);
        end
        checks++;
        if (if0.first_fail_vec !== 4'd5 || if0.first_fail_mask !== 4'b0100) begin
            failures++;
            $display("FAIL fault_capture: got vec=%0d mask=%b expected vec=5 mask=0100",
                     if0.first_fail_vec, if0.first_fail_mask);
        end
        checks++;
        if ({if0.done, if0.pass, if0.fail_seen} !== 3'b101) begin
            failures++;
            $display("FAIL fault_verdict: got done/pass/fail=%b expected 101",
                     {if0.done, if0.pass, if0.fail_seen});
        end
    endtask

    task automatic test_gaps_and_ignored();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(0, 1, 4'(i), agree(4'(i)));
            // invalid cycles carry a disagreeing vector that must be ignored
            if (i != 15) cyc(0, 0, 4'hA, 4'b1010);
        end
        checks++;
        if (if0.vec_cnt !== 5'd15 || if0.done !== 1'b0) begin
            failures++;
            $display("FAIL gaps_before_last: got vec=%0d done=%b expected vec=15 done=0",
                     if0.vec_cnt, if0.done);
        end
        idle();
        checks++;
        if (if0.vec_cnt !== 5'd16 || if0.done !== 1'b1 || if0.err_cnt !== 8'd0) begin
            failures++;
            $display("FAIL gaps_done: got vec=%0d done=%b err=%0d expected vec=16 done=1 err=0",
                     if0.vec_cnt, if0.done, if0.err_cnt);
        end
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i), 4'b0110);
        idle();
        checks++;
        if (if0.vec_cnt !== 5'd16 || if0.err_cnt !== 8'd0 || if0.done !== 1'b1) begin
            failures++;
            $display("FAIL ignored_in_done: got vec=%0d err=%0d done=%b expected 16 0 1",
                     if0.vec_cnt, if0.err_cnt, if0.done);
        end
        do_reset();
        for (int i = 0; i < 3; i++) cyc(0, 1, 4'(i), 4'b0110);
        idle();
        checks++;
        if (if0.vec_cnt !== 5'd0 || if0.err_cnt !== 8'd0 || if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignored_in_idle: got vec=%0d err=%0d busy=%b expected 0 0 0",
                     if0.vec_cnt, if0.err_cnt, if0.busy);
        end
    endtask

    task automatic test_restart();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            if (i == 3) cyc(0, 1, 4'(i), 4'b1000);
            else cyc(0, 1, 4'(i), agree(4'(i)));
        end
        // restart coincides with a disagreeing valid sample, which must be dropped
        cyc(1, 1, 4'hF, 4'b0010);
        idle();
        checks++;
        if (if0.vec_cnt !== 5'd0 || if0.err_cnt !== 8'd0 || if0.fail_seen !== 1'b0
            || if0.first_fail_vec !== 4'd0 || if0.busy !== 1'b1) begin
            failures++;
            $display("FAIL restart_clear: got vec=%0d err=%0d fail=%b fvec=%0d busy=%b",
                     if0.vec_cnt, if0.err_cnt, if0.fail_seen, if0.first_fail_vec, if0.busy);
        end
        for (int i = 0; i < 15; i++) cyc(0, 1, 4'(i), agree(4'(i)));
        idle();
        checks++;
        if (if0.done !== 1'b0 || if0.vec_cnt !== 5'd15) begin
            failures++;
            $display("FAIL restart_needs_16: got done=%b vec=%0d expected done=0 vec=15",
                     if0.done, if0.vec_cnt);
        end
        cyc(0, 1, 4'd15, agree(4'd15));
        idle();
        checks++;
        if (if0.done !== 1'b1 || if0.pass !== 1'b1) begin
            failures++;
            $display("FAIL restart_done: got done=%b pass=%b expected 1 1", if0.done, if0.pass);
        end
    endtask

    task automatic test_reset_mid_sweep();
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i == 2) cyc(0, 1, 4'(i), 4'b0100);
            else cyc(0, 1, 4'(i), agree(4'(i)));
        end
        do_reset();
        checks++;
        if ({if0.busy, if0.done, if0.pass, if0.fail_seen, if0.err_cnt, if0.vec_cnt,
             if0.first_fail_vec, if0.first_fail_mask} !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid_sweep: got %h expected 0",
                     {if0.busy, if0.done, if0.pass, if0.fail_seen, if0.err_cnt, if0.vec_cnt,
                      if0.first_fail_vec, if0.first_fail_mask});
        end
        // IDLE: a valid sample without start must stay ignored
        cyc(0, 1, 4'd1, 4'b0010);
        idle();
        checks++;
        if (if0.vec_cnt !== 5'd0 || if0.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_to_idle: got vec=%0d busy=%b expected 0 0",
                     if0.vec_cnt, if0.busy);
        end
    endtask

    task automatic test_coverage();
        bit exp_pass;
`ifdef COMB_CHK_COVERAGE_EN
        exp_pass = 0;
`else
        exp_pass = 1;
`endif
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = (i == 12) ? 4'd3 : 4'(i);
            cyc(0, 1, v, agree(v));
        end
        idle();
        checks++;
        if (if0.err_cnt !== 8'd0 || if0.vec_cnt !== 5'd16 || if0.done !== 1'b1) begin
            failures++;
            $display("FAIL coverage_counts: got err=%0d vec=%0d done=%b expected 0 16 1",
                     if0.err_cnt, if0.vec_cnt, if0.done);
        end
        checks++;
        if (if0.pass !== exp_pass) begin
            failures++;
            $display("FAIL coverage_pass: got %b expected %b", if0.pass, exp_pass);
        end
    endtask

    task automatic test_random();
        for (int sweep = 0; sweep < 6; sweep++) begin
            cyc(1, 0, 0, 0);
            for (int n = 0; n < 120; n++) begin
                logic [3:0] v, mo;
                bit s, val;
                @(negedge clk);
                checks++;
                if ({if0.busy, if0.done, if0.pass, if0.fail_seen, if0.err_cnt, if0.vec_cnt,
                     if0.first_fail_vec, if0.first_fail_mask} !==
                    {m_busy, m_done, m_pass, m_fail, 8'(m_err), 5'(m_cnt), m_fvec, m_fmask}) begin
                    failures++;
                    $display("FAIL random_cycle: got %h expected %h",
                             {if0.busy, if0.done, if0.pass, if0.fail_seen, if0.err_cnt,
                              if0.vec_cnt, if0.first_fail_vec, if0.first_fail_mask},
                             {m_busy, m_done, m_pass, m_fail, 8'(m_err), 5'(m_cnt), m_fvec,
                              m_fmask});
                end
                if (m_done) break;
                v   = 4'($urandom_range(0, 15));
                mo  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : agree(v);
                val = ($urandom_range(0, 9) < 7);
                s   = ($urandom_range(0, 59) == 0);
                if0.start = s; if0.in_valid = val; if0.in_vec = v; if0.model_out = mo;
                model_step(s, val, v, mo);
            end
            checks++;
            if (if0.done !== 1'b1) begin
                failures++;
                $display("FAIL random_sweep_end: got done=%b expected 1", if0.done);
            end
        end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        if2.start = 1; if2.in_valid = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if2.start = 0; if2.in_valid = 1; if2.in_vec = 4'(i); if2.model_out = 4'b0010;
        end
        @(negedge clk);
        if2.in_valid = 0;
        checks++;
        if (if2.err_cnt !== 2'd3) begin
            failures++; $display("FAIL sat_err_cnt: got %0d expected 3", if2.err_cnt);
        end
        checks++;
        if ({if2.done, if2.pass, if2.fail_seen} !== 3'b101 || if2.first_fail_mask !== 4'b0010
            || if2.first_fail_vec !== 4'd0 || if2.vec_cnt !== 5'd16) begin
            failures++;
            $display("FAIL sat_verdict: got dpf=%b mask=%b fvec=%0d vec=%0d expected 101 0010 0 16",
                     {if2.done, if2.pass, if2.fail_seen}, if2.first_fail_mask,
                     if2.first_fail_vec, if2.vec_cnt);
        end
    endtask

    initial begin
        if0.start = 0; if0.in_valid = 0; if0.in_vec = 0; if0.model_out = 0;
        if2.start = 0; if2.in_valid = 0; if2.in_vec = 0; if2.model_out = 0;
        model_clear();
        m_busy = 0; m_done = 0;
        test_reset();
        test_clean_sweep();
        test_fault();
        test_gaps_and_ignored();
        test_restart();
        test_reset_mid_sweep();
        test_coverage();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/comb_vec_checker.md
# comb_vec_checker

Self-checking result stage that sits directly downstream of the four 4-input combinational implementations (structural, dataflow, behavioral, primitive). Each valid cycle it samples the applied input vector and the four model outputs, flags any disagreement against model 0, counts errors, captures the first failing vector, and tracks which of the 2^VEC_W vectors have been exercised. After a full sweep it reports a registered pass/fail verdict, replacing manual inspection of `$monitor` logs.

## Interface
- `VEC_W`, 4, input vector width; the sweep length is 2^VEC_W vectors.
- `NUM_MODELS`, 4, number of compared model outputs; model 0 is the golden reference.
- `CNT_W`, 8, width of the saturating error counter.

- `clk`  in  1  sole clock, rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins or restarts a sweep.
- `in_valid`  in  1  `in_vec`/`model_out` valid this cycle.
- `in_vec`  in  VEC_W  applied input vector, {A,B,C,D} with A as MSB.
- `model_out`  in  NUM_MODELS  model outputs; bit 0 is the golden model.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE until the next `start` or `rst`.
- `pass`  out  1  verdict; meaningful only while `done` is high.
- `err_cnt`  out  CNT_W  mismatching samples, saturating.
- `vec_cnt`  out  VEC_W+1  samples accepted in the current sweep.
- `fail_seen`  out  1  at least one mismatch this sweep.
- `first_fail_vec`  out  VEC_W  `in_vec` of the first mismatch.
- `first_fail_mask`  out  NUM_MODELS  per-model disagreement mask at the first mismatch; bit i = `model_out[i] ^ model_out[0]`, bit 0 always 0.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE when an accepted sample brings `vec_cnt` to 2^VEC_W.
  - DONE → RUN on `start`.
  - `start` in RUN restarts the sweep (clears all statistics and stays in RUN).
- On entry to RUN, clear `err_cnt`, `vec_cnt`, `fail_seen`, `first_fail_*` and the coverage bitmap.
- Acceptance: a sample is accepted only when the FSM is in RUN and `in_valid`=1. When accepted:
  - `vec_cnt` increments.
  - Mismatch is `|(model_out ^ {NUM_MODELS{model_out[0]}})`.
  - On a mismatch, `err_cnt` increments and saturates at 2^CNT_W−1.
  - On the first mismatch only (`fail_seen`=0), capture `first_fail_vec` and `first_fail_mask`, then set `fail_seen`.
- `in_valid` is ignored in IDLE and DONE.
- `start` and `in_valid` in the same cycle: `start` wins and the sample is discarded.
- `pass` = (`err_cnt`==0) && coverage_ok, registered on the RUN→DONE transition.
- Repeated vectors within a sweep are counted normally. Duplicates reduce coverage but are not errors.

## Timing
- All outputs are registered. Statistics and capture fields reflect a sample one cycle after acceptance.
- `done` rises the cycle after the 2^VEC_W-th accepted sample, with `pass` valid in that same cycle.
- `busy` rises the cycle after `start`.
- Reset values:
  - State IDLE.
  - `busy`=0, `done`=0, `pass`=0, `fail_seen`=0.
  - `err_cnt`=0, `vec_cnt`=0.
  - `first_fail_vec`=0, `first_fail_mask`=0.
  - Coverage bitmap all 0.
- `rst` mid-sweep aborts the sweep immediately and applies the reset values. No verdict is produced.

## Configuration
- `COMB_CHK_COVERAGE_EN` defined:
  - A 2^VEC_W-bit bitmap sets bit `in_vec` on every accepted sample.
  - coverage_ok = bitmap all-ones.
  - An exhaustive sweep containing a duplicate, and therefore a missing vector, yields `pass`=0.
- Undefined: there is no bitmap, coverage_ok is constant 1, and `pass` depends on `err_cnt` alone.

## Structure
- Package `comb_chk_pkg`:
  - State enum `chk_state_t` {IDLE, RUN, DONE}.
  - Default `VEC_W`/`NUM_MODELS`/`CNT_W` constants.
  - The `SWEEP_LEN` = 1<<VEC_W localparam helper.
- One sub-module, `sat_counter` (parameterised width, synchronous clear, enable, saturate at max), used for `err_cnt`.
- `vec_cnt` is a plain counter.

## Test plan
- Clean sweep: `start`, then 16 valid cycles with `in_vec`=0..15 and all `model_out` equal to the golden function → `done`=1 one cycle after the last sample, `pass`=1, `err_cnt`=0, `vec_cnt`=16, `fail_seen`=0.
- Injected fault: force `model_out[2]`=~golden at `in_vec`=5 and 9 → `err_cnt`=2, `first_fail_vec`=5, `first_fail_mask`=4'b0100, `pass`=0.
- Gaps and ignored input:
  - `in_valid` held low on alternate cycles → `vec_cnt` counts only valid samples and `done` follows the 16th.
  - `in_valid` in IDLE/DONE → no counter change.
- Restart and reset:
  - `start` after sample 7 → counters clear and a further 16 samples are required.
  - `rst` after sample 10 → all outputs at reset values and the FSM in IDLE.
- Coverage (macro defined): `in_vec` 3 repeated in place of 12, outputs all agree → `err_cnt`=0, `pass`=0. With the macro undefined, the same stimulus gives `pass`=1.
- Saturation: CNT_W=2 with 16 mismatching samples → `err_cnt` holds at 3.
